// File: rtl/sb_pkg.sv
// Shared types and default widths for the MEM-stage store buffer.
package sb_pkg;
    localparam int ADDR_W        = 8;
    localparam int DATA_W        = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/store_fwd_match.sv
// Store-to-load forwarding match: scans pending entries oldest to youngest from head,
// so the last match seen is the youngest one.
module store_fwd_match
    import sb_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PW    = $clog2(DEPTH)
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (entries[idx].valid && entries[idx].addr == ld_addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer ahead of the data memory: queues stores, drains one per cycle
// when no load miss needs the port, and forwards pending store data to loads.
module store_buffer
    import sb_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    parameter  int ADDR_W = sb_pkg::ADDR_W,
    parameter  int DATA_W = sb_pkg::DATA_W,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read_write,
    output logic              empty,
    output logic [CW-1:0]     count
);

    sb_entry_t         entries [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              match_hit;
    logic [DATA_W-1:0] match_data;
    logic              push;
    logic              drain;
    logic              load_miss;

    store_fwd_match #(.DEPTH(DEPTH)) u_match (
        .entries (entries),
        .head    (head),
        .ld_addr (ld_addr),
        .hit     (match_hit),
        .data    (match_data)
    );

    assign st_ready  = (count != CW'(DEPTH));
    assign empty     = (count == '0);
    assign ld_hit    = ld_valid && match_hit;
    assign ld_data   = ld_hit ? match_data : '0;
    assign load_miss = ld_valid && !match_hit;
    assign push      = st_valid && st_ready;
    assign drain     = !empty && !load_miss;

    always_comb begin
        mem_read_write = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (load_miss) begin
            mem_address = ld_addr;
        end else if (drain) begin
            mem_read_write = 1'b1;
            mem_address    = entries[head].addr;
            mem_write_data = entries[head].data;
        end
    end

    // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
                tail          <= tail + PW'(1);
            end
            if (drain) begin
                entries[head].valid <= 1'b0;
                head                <= head + PW'(1);
            end
            if (push && !drain) begin
                count <= count + CW'(1);
            end else if (!push && drain) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed plus random checks of store_buffer against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       st_valid;
    logic [7:0] st_addr;
    logic [7:0] st_data;
    logic       st_ready;
    logic       ld_valid;
    logic [7:0] ld_addr;
    logic       ld_hit;
    logic [7:0] ld_data;
    logic [7:0] mem_address;
    logic [7:0] mem_write_data;
    logic       mem_read_write;
    logic       empty;
    logic [2:0] count;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_hit         (ld_hit),
        .ld_data        (ld_data),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_write (mem_read_write),
        .empty          (empty),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory driven by the DUT's port, and the reference model's view of it.
    logic [7:0] mem_dut   [256];
    logic [7:0] mem_model [256];

    always @(posedge clk) begin
        if (mem_read_write) mem_dut[mem_address] <= mem_write_data;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;

    ent_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_st_ready", 32'(st_ready), 1);
        chk("rst_mem_rw", 32'(mem_read_write), 0);
        chk("rst_mem_addr", 32'(mem_address), 0);
        chk("rst_mem_wdata", 32'(mem_write_data), 0);
        chk("rst_ld_hit", 32'(ld_hit), 0);
        chk("rst_ld_data", 32'(ld_data), 0);
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the model,
    // then advance the model across the rising edge.
    task automatic cycle(input logic sv, input logic [7:0] sa, input logic [7:0] sd,
                         input logic lv, input logic [7:0] la);
        logic       e_hit;
        logic [7:0] e_data;
        logic       miss;
        logic       drn;
        logic       acc;
        logic       e_rw;
        logic [7:0] e_addr;
        logic [7:0] e_wd;
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la;
        #2;
        e_hit = 1'b0; e_data = 8'h00;
        if (lv) begin
            foreach (q[i]) begin
                if (q[i].a == la) begin
                    e_hit  = 1'b1;
                    e_data = q[i].d;
                end
            end
        end
        miss = lv && !e_hit;
        drn  = (q.size() != 0) && !miss;
        acc  = sv && (q.size() < DEPTH);
        e_rw = 1'b0; e_addr = 8'h00; e_wd = 8'h00;
        if (miss) e_addr = la;
        else if (drn) begin
            e_rw = 1'b1; e_addr = q[0].a; e_wd = q[0].d;
        end
        chk("ld_hit", 32'(ld_hit), 32'(e_hit));
        chk("ld_data", 32'(ld_data), 32'(e_data));
        chk("mem_read_write", 32'(mem_read_write), 32'(e_rw));
        chk("mem_address", 32'(mem_address), 32'(e_addr));
        chk("mem_write_data", 32'(mem_write_data), 32'(e_wd));
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
        @(posedge clk);
        if (drn) begin
            mem_model[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (acc) q.push_back('{a: sa, d: sd});
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 256; i++) begin
            mem_dut[i]   = 8'h00;
            mem_model[i] = 8'h00;
        end
        rst = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0;
        @(posedge clk); @(posedge clk); #1;
        chk_reset_outputs();
        rst = 1'b0;

        // Reset then idle
        idle(5);

        // Single store, drained the following cycle
        cycle(1'b1, 8'h64, 8'hA5, 1'b0, 8'h00);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("single_mem64", 32'(mem_dut[8'h64]), 32'h0000_00A5);
        chk("single_empty", 32'(empty), 1);

        // Fill while a load miss holds the port; fifth store is refused
        for (int k = 0; k < 4; k++) cycle(1'b1, 8'h30 + 8'(k), 8'hC0 + 8'(k), 1'b1, 8'h10);
        chk("fill_count", 32'(count), 4);
        chk("fill_ready", 32'(st_ready), 0);
        cycle(1'b1, 8'h20, 8'hEE, 1'b1, 8'h10);
        chk("fill_refused", 32'(count), 4);
        idle(4);
        chk("fill_drained", 32'(empty), 1);
        chk("fill_mem20", 32'(mem_dut[8'h20]), 0);

        // Forwarding priority: youngest of duplicate addresses wins
        cycle(1'b1, 8'h65, 8'h11, 1'b1, 8'h10);
        cycle(1'b1, 8'h65, 8'h22, 1'b1, 8'h10);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 8'h65);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 8'h66);
        idle(3);
        chk("dup_mem65", 32'(mem_dut[8'h65]), 32'h0000_0022);

        // Same-cycle store and load to the same address on an empty buffer
        cycle(1'b1, 8'h67, 8'h5A, 1'b1, 8'h67);
        chk("same_cycle_count", 32'(count), 1);
        idle(2);

        // Randomised traffic over a small address window to force hits and duplicates
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), 8'h80 + 8'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom_range(0, 9) < 4), 8'h80 + 8'($urandom_range(0, 9)));
        end
        idle(DEPTH + 1);

        // Reset mid-drain discards the queue immediately
        for (int k = 0; k < 3; k++) cycle(1'b1, 8'h40 + 8'(k), 8'h70 + 8'(k), 1'b1, 8'h10);
        st_valid = 1'b0; ld_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_mem_rw", 32'(mem_read_write), 0);
        q.delete();
        @(posedge clk); #1;
        chk_reset_outputs();
        rst = 1'b0;
        idle(4);

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem_dut[i] !== mem_model[i]) bad++;
        end
        chk("memory_image_diffs", 32'(bad), 0);
        chk("midrst_no_write", 32'(mem_dut[8'h40]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-buffering stage directly upstream of the 8-bit data memory in the MIPS pipeline's MEM stage. Stores from the EX/MEM register are queued in a small in-order FIFO and drained to memory one per cycle whenever the memory port is not needed by a load. Loads are checked against all pending stores and served by forwarding from the youngest matching entry. Loads that miss get the memory port that cycle.

## Interface
- DEPTH, 4, number of buffer entries; power of two, 2..16
- ADDR_W, 8, address width
- DATA_W, 8, data width

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- st_valid  in  1  store issued this cycle
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- st_ready  out  1  buffer not full; pipeline stalls the store when low
- ld_valid  in  1  load issued this cycle
- ld_addr  in  ADDR_W  load address
- ld_hit  out  1  load address matches a pending store (combinational)
- ld_data  out  DATA_W  forwarded data, valid when ld_hit
- mem_address  out  ADDR_W  data memory address
- mem_write_data  out  DATA_W  data memory write data
- mem_read_write  out  1  1 = write this cycle, 0 = read/idle
- empty  out  1  no pending stores
- count  out  $clog2(DEPTH)+1  number of pending stores

## Operation
- Circular FIFO: head (oldest) and tail pointers, each $clog2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- Push: st_valid && st_ready writes {st_addr, st_data} at tail on the edge; tail++ and count++.
- st_ready = (count != DEPTH). No push-through: a store presented while full is ignored, even if a pop occurs that cycle.
- Load miss = ld_valid && !ld_hit.
- Drain condition = !empty && !load miss.
- Drain: mem_read_write=1, mem_address/mem_write_data = head entry. Head entry pops on the same edge the memory captures it; head++ and count--.
- Load miss: mem_read_write=0, mem_address=ld_addr. Drain is blocked that cycle and the head is held.
- Idle (empty, no load miss): mem_read_write=0, mem_address=0, mem_write_data=0. Also mem_write_data=0 whenever not draining.
- Forwarding: compare ld_addr against every valid entry, including the head being drained this cycle. ld_hit=1 if any entry matches. ld_data = data of the youngest match (closest to tail). ld_hit=0 and ld_data=0 when !ld_valid.
- Simultaneous store and load: both are accepted. The load does not see the same-cycle store, because the load is older in program order.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Duplicate addresses in the buffer are legal. They drain in order, so memory ends holding the youngest value.

## Timing
- Reset (async assert, sync-free deassert): head=tail=0, count=0, all entries invalid. Outputs: st_ready=1, empty=1, count=0, mem_read_write=0, mem_address=0, mem_write_data=0, ld_hit=0, ld_data=0.
- rst asserted mid-operation discards all pending stores immediately; no partial drain completes.
- Store accepted at edge N is drainable in cycle N..N+1. It is written to memory at edge N+1 at the earliest.
- Forwarding latency is zero cycles, within the load's cycle. A store accepted at edge N is forwardable from cycle N+1 until its pop edge.
- Memory read latency is unchanged for loads: same-cycle address presentation.
- Drain throughput is 1 store/cycle. Every load miss delays the drain by exactly one cycle.

## Structure
- Package sb_pkg: ADDR_W=8, DATA_W=8, DEFAULT_DEPTH=4, and typedef sb_entry_t {valid, addr, data}.
- Sub-module store_fwd_match: takes the entry array, the head pointer and ld_addr. It outputs hit and the youngest-match data, scanning by age starting from the head.
- Top level holds the FIFO registers, pointers, count and memory-port mux.

## Test plan
- Reset then idle: after rst=1→0, expect st_ready=1, empty=1, mem_read_write=0, mem_address=0 for 5 cycles.
- Single store (0x64, 0xA5), no loads: mem_read_write=1 with addr 0x64 / data 0xA5 in the next cycle. Memory[0x64]=0xA5 afterwards, and empty=1 one edge after the write.
- Fill: 4 back-to-back stores while a load miss to 0x10 is held every cycle. count reaches 4 and st_ready=0. A 5th store to 0x20 is not accepted. Releasing the load drains 4 stores in 4 cycles, in order.
- Forwarding priority: store (0x65, 0x11) then (0x65, 0x22) with drain blocked, then a load from 0x65 gives ld_hit=1, ld_data=0x22. A load from 0x66 gives ld_hit=0 and mem_address=0x66, mem_read_write=0.
- Same-cycle store and load to 0x67 with an empty buffer: ld_hit=0 and the memory read proceeds. The store is accepted with count=1.
- Reset mid-drain: with 3 pending stores, assert rst between edges. count=0, empty=1 and mem_read_write=0 immediately, and no further writes reach memory.
